// File: rtl/fifo_param_flags.sv
// Parametrised synchronous FIFO with occupancy count, almost-full/almost-empty flags and
// underflow/overflow error outputs. Define FIFO_STICKY_ERR_EN for sticky errors (default: 1-cycle pulses).
module fifo_param_flags #(
  parameter int DATA_WIDTH      = 8,
  parameter int ADDR_WIDTH      = 2,
  parameter int ALMOST_FULL_TH  = 3,
  parameter int ALMOST_EMPTY_TH = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  wr,
  input  logic                  rd,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  outEmpty,
  output logic                  outFull,
  output logic                  almostEmpty,
  output logic                  almostFull,
  output logic                  errorEmpty,
  output logic                  errorFull
);

  localparam int CW    = ADDR_WIDTH + 1;
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] LP_DEPTH = CW'(DEPTH);
  localparam logic [ADDR_WIDTH:0] LP_AF_TH = CW'(ALMOST_FULL_TH);
  localparam logic [ADDR_WIDTH:0] LP_AE_TH = CW'(ALMOST_EMPTY_TH);
  localparam logic [ADDR_WIDTH:0] LP_ONE   = CW'(1);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_count;
  logic [DATA_WIDTH-1:0] r_data_out;
  logic                  r_err_empty;
  logic                  r_err_full;

  logic w_wv;
  logic w_rv;
  logic w_empty_evt;
  logic w_full_evt;

  // Flags are pure decodes of the registered count, so they change on the same edge as count.
  assign outEmpty    = (r_count == '0);
  assign outFull     = (r_count == LP_DEPTH);
  assign almostEmpty = (r_count <= LP_AE_TH);
  assign almostFull  = (r_count >= LP_AF_TH);

  // A read at full frees a slot in the same edge, so the concurrent write is accepted.
  assign w_wv        = en & wr & (~outFull | rd);
  assign w_rv        = en & rd & ~outEmpty;
  assign w_empty_evt = rd & outEmpty;
  assign w_full_evt  = wr & outFull & ~rd;

  always_ff @(posedge clk) begin
    if (w_wv) begin
      r_mem[r_wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_data_out <= '0;
    end else begin
      if (w_wv) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_rv) begin
        r_data_out <= r_mem[r_rd_ptr];
        r_rd_ptr   <= r_rd_ptr + 1'b1;
      end
      case ({w_wv, w_rv})
        2'b10:   r_count <= r_count + LP_ONE;
        2'b01:   r_count <= r_count - LP_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_err_empty <= 1'b0;
      r_err_full  <= 1'b0;
    end else if (en) begin
`ifdef FIFO_STICKY_ERR_EN
      r_err_empty <= r_err_empty | w_empty_evt;
      r_err_full  <= r_err_full | w_full_evt;
`else
      r_err_empty <= w_empty_evt;
      r_err_full  <= w_full_evt;
`endif
    end
  end

  assign data_out   = r_data_out;
  assign count      = r_count;
  assign errorEmpty = r_err_empty;
  assign errorFull  = r_err_full;

endmodule

// File: tb/tb_fifo_param_flags.sv
// Bench for fifo_param_flags: queue-based reference model, expected-state scoreboard and
// a monitor that compares every clocked output state. Honours FIFO_STICKY_ERR_EN.
module tb_fifo_param_flags;

  localparam int DW    = 8;
  localparam int AW    = 2;
  localparam int DEPTH = 1 << AW;
  localparam int AF_TH = 3;
  localparam int AE_TH = 1;
  localparam int VW    = DW + AW + 1 + 6;

  logic          clk;
  logic          reset;
  logic          en;
  logic          wr;
  logic          rd;
  logic [DW-1:0] data_in;
  logic [DW-1:0] data_out;
  logic [AW:0]   count;
  logic          outEmpty;
  logic          outFull;
  logic          almostEmpty;
  logic          almostFull;
  logic          errorEmpty;
  logic          errorFull;

  fifo_param_flags #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .ALMOST_FULL_TH(AF_TH),
    .ALMOST_EMPTY_TH(AE_TH)
  ) dut (
    .clk(clk),
    .reset(reset),
    .en(en),
    .wr(wr),
    .rd(rd),
    .data_in(data_in),
    .data_out(data_out),
    .count(count),
    .outEmpty(outEmpty),
    .outFull(outFull),
    .almostEmpty(almostEmpty),
    .almostFull(almostFull),
    .errorEmpty(errorEmpty),
    .errorFull(errorFull)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: contents as a plain queue, plus last read word and error flags
  logic [DW-1:0] m_q[$];
  logic [DW-1:0] m_dout;
  logic          m_ee;
  logic          m_fe;

  // scoreboard
  logic [VW-1:0] exp_q[$];
  string         tag_q[$];
  int            n_cmp;
  int            n_bad;

  localparam logic [VW-1:0] RESET_VEC = {8'h00, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

  function automatic logic [VW-1:0] model_vec();
    int n;
    n = m_q.size();
    return {m_dout, 3'(n), (n == 0), (n == DEPTH), (n <= AE_TH), (n >= AF_TH), m_ee, m_fe};
  endfunction

  function automatic logic [VW-1:0] dut_vec();
    return {data_out, count, outEmpty, outFull, almostEmpty, almostFull, errorEmpty, errorFull};
  endfunction

  task automatic check(input string name, input logic [VW-1:0] e, input logic [VW-1:0] a);
    n_cmp++;
    if (e !== a) begin
      n_bad++;
      $display("FAIL %s expected{dout,cnt,E,F,AE,AF,errE,errF}=%h actual=%h (t=%0t)", name, e, a, $time);
    end
  endtask

  // driver: apply one cycle of stimulus and push the post-edge state the model predicts
  task automatic step(input logic i_en, input logic i_wr, input logic i_rd,
                      input logic [DW-1:0] d, input string tag);
    int  n;
    logic ee_evt;
    logic fe_evt;
    @(negedge clk);
    en = i_en; wr = i_wr; rd = i_rd; data_in = d;
    if (i_en) begin
      n      = m_q.size();
      ee_evt = i_rd && (n == 0);
      fe_evt = i_wr && (n == DEPTH) && !i_rd;
      if (i_rd && n > 0) m_dout = m_q.pop_front();
      if (i_wr && (n < DEPTH || i_rd)) m_q.push_back(d);
`ifdef FIFO_STICKY_ERR_EN
      m_ee = m_ee | ee_evt;
      m_fe = m_fe | fe_evt;
`else
      m_ee = ee_evt;
      m_fe = fe_evt;
`endif
    end
    exp_q.push_back(model_vec());
    tag_q.push_back(tag);
  endtask

  task automatic model_reset();
    m_q.delete();
    m_dout = '0;
    m_ee   = 1'b0;
    m_fe   = 1'b0;
  endtask

  // async reset asserted between edges; outputs must clear without waiting for a clock
  task automatic mid_reset(input string tag);
    @(posedge clk);
    #2;
    reset = 1'b0;
    en = 1'b0; wr = 1'b0; rd = 1'b0;
    #1;
    model_reset();
    check(tag, RESET_VEC, dut_vec());
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  // monitor: compare the DUT state after every clock edge that has a prediction pending
  always @(posedge clk) begin
    logic [VW-1:0] e;
    string         t;
    #1;
    if (reset && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check(t, e, dut_vec());
    end
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;
    model_reset();
    reset = 1'b0; en = 1'b0; wr = 1'b0; rd = 1'b0; data_in = '0;
    #7;
    check("reset_initial", RESET_VEC, dut_vec());
    @(negedge clk);
    reset = 1'b1;

    // fill to full, then overflow attempt
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 8'hA1 + 8'(i), $sformatf("fill_%0d", i));
    step(1'b1, 1'b1, 1'b0, 8'hFF, "overflow");
    step(1'b1, 1'b0, 1'b0, 8'h00, "after_overflow");
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1, 8'h00, $sformatf("drain_%0d", i));
    step(1'b1, 1'b0, 1'b1, 8'h00, "underflow");

    // interleaved traffic walks the pointers past the wrap point
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b1, 1'b0, 8'hB0 + 8'(i), $sformatf("wrap_wr_%0d", i));
      step(1'b1, 1'b0, 1'b1, 8'h00, $sformatf("wrap_rd_%0d", i));
    end

    // simultaneous read/write at full, then at empty
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 8'hC1 + 8'(i), $sformatf("refill_%0d", i));
    step(1'b1, 1'b1, 1'b1, 8'h55, "full_rdwr");
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1, 8'h00, $sformatf("drain55_%0d", i));
    step(1'b1, 1'b1, 1'b1, 8'h66, "empty_rdwr");
    step(1'b1, 1'b0, 1'b1, 8'h00, "read_66");

    // enable low freezes everything; then underflow followed by idle
    step(1'b1, 1'b1, 1'b0, 8'h77, "pre_freeze_wr");
    step(1'b0, 1'b1, 1'b1, 8'h88, "frozen_0");
    step(1'b0, 1'b1, 1'b1, 8'h99, "frozen_1");
    step(1'b1, 1'b0, 1'b1, 8'h00, "read_77");
    step(1'b1, 1'b0, 1'b1, 8'h00, "underflow_2");
    step(1'b1, 1'b0, 1'b0, 8'h00, "idle_after_uf_0");
    step(1'b0, 1'b0, 1'b0, 8'h00, "idle_disabled");
    step(1'b1, 1'b0, 1'b0, 8'h00, "idle_after_uf_1");

    // reset with data inside
    step(1'b1, 1'b1, 1'b0, 8'h12, "pre_reset_wr0");
    step(1'b1, 1'b1, 1'b0, 8'h34, "pre_reset_wr1");
    mid_reset("reset_mid_op");
    step(1'b1, 1'b0, 1'b1, 8'h00, "post_reset_rd");
    step(1'b1, 1'b1, 1'b0, 8'h5A, "post_reset_wr");
    step(1'b1, 1'b0, 1'b1, 8'h00, "post_reset_rd_5a");

    // random traffic with phases biased towards filling and draining
    for (int i = 0; i < 400; i++) begin
      int wr_bias;
      wr_bias = ((i / 50) % 2 == 0) ? 7 : 3;
      step(($urandom_range(0, 9) != 0),
           ($urandom_range(0, 9) < wr_bias),
           ($urandom_range(0, 9) >= wr_bias),
           8'($urandom), $sformatf("rand_%0d", i));
    end

    @(negedge clk);
    en = 1'b0; wr = 1'b0; rd = 1'b0;
    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain pending=%0d required=0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
